// File: rtl/pe_chain_feeder.sv
// rtl/pe_chain_feeder.sv - weight loader and activation streamer for the input side of a linear PE chain
module pe_chain_feeder #(
    parameter int DATA_W    = 8,
    parameter int SUM_W     = 16,
    parameter int CHAIN_LEN = 4,
    parameter int AW        = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_wr_en,
    input  logic [AW-1:0]     cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [SUM_W-1:0]  bias,
    input  logic              act_valid,
    input  logic [DATA_W-1:0] act_data,
    output logic              act_ready,
    output logic              pe_active,
    output logic [DATA_W-1:0] pe_datain,
    output logic [DATA_W-1:0] pe_win,
    output logic              pe_wwrite,
    output logic [SUM_W-1:0]  pe_sumin,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_wbuf [CHAIN_LEN];
    logic [DATA_W-1:0]   r_wjob [CHAIN_LEN];
    logic [AW-1:0]       r_idx;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_num_vec;
    logic [SUM_W-1:0]    r_bias;

    logic                w_idle;
    logic                w_start_acc;
    logic                w_hs;
    logic                w_last_idx;
    logic [AW-1:0]       w_load_sel;
    logic [CNT_W-1:0]    w_count_inc;

    assign w_idle      = (r_state == S_IDLE);
    assign w_start_acc = start && w_idle;
    assign act_ready   = (r_state == S_STREAM) && (r_count < r_num_vec);
    assign w_hs        = act_valid && act_ready;
    assign w_last_idx  = (r_idx == AW'(CHAIN_LEN - 1));
    assign w_load_sel  = AW'(CHAIN_LEN - 1) - r_idx;
    assign w_count_inc = r_count + 1'b1;

    // Host-visible weight buffer; writable only while no job is running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                r_wbuf[i] <= '0;
            end
        end else if (cfg_wr_en && w_idle) begin
            r_wbuf[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // Job copy is taken from the pre-edge buffer so a write landing with start stays out of this job.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_count   <= '0;
            r_num_vec <= '0;
            r_bias    <= '0;
            pe_active <= 1'b0;
            pe_datain <= '0;
            pe_win    <= '0;
            pe_wwrite <= 1'b0;
            pe_sumin  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < CHAIN_LEN; i++) begin
                r_wjob[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    pe_active <= 1'b0;
                    pe_datain <= '0;
                    pe_win    <= '0;
                    pe_wwrite <= 1'b0;
                    pe_sumin  <= '0;
                    busy      <= 1'b0;
                    if (w_start_acc) begin
                        r_num_vec <= num_vec;
                        r_bias    <= bias;
                        r_idx     <= '0;
                        r_count   <= '0;
                        busy      <= 1'b1;
                        for (int i = 0; i < CHAIN_LEN; i++) begin
                            r_wjob[i] <= r_wbuf[i];
                        end
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    pe_wwrite <= 1'b1;
                    pe_win    <= r_wjob[w_load_sel];
                    pe_active <= 1'b0;
                    pe_datain <= '0;
                    pe_sumin  <= '0;
                    if (w_last_idx) begin
                        r_idx   <= '0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_SETTLE: begin
                    pe_wwrite <= 1'b0;
                    pe_win    <= '0;
                    r_state   <= (r_num_vec == '0) ? S_DRAIN : S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        pe_active <= 1'b1;
                        pe_datain <= act_data;
                        pe_sumin  <= r_bias;
                        r_count   <= w_count_inc;
                        if (w_count_inc == r_num_vec) begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        pe_active <= 1'b0;
                        pe_datain <= '0;
                        pe_sumin  <= '0;
                    end
                end
                S_DRAIN: begin
                    pe_active <= 1'b0;
                    pe_datain <= '0;
                    pe_sumin  <= '0;
                    if (w_last_idx) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_chain_feeder.sv
// tb/tb_pe_chain_feeder.sv - randomized self-checking bench for pe_chain_feeder against a cycle-schedule model
module tb_pe_chain_feeder;

    localparam int DW = 8;
    localparam int SW = 16;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_wr_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [DW-1:0] cfg_wr_data;
    logic          start;
    logic [CW-1:0] num_vec;
    logic [SW-1:0] bias;
    logic          act_valid;
    logic [DW-1:0] act_data;
    logic          act_ready;
    logic          pe_active;
    logic [DW-1:0] pe_datain;
    logic [DW-1:0] pe_win;
    logic          pe_wwrite;
    logic [SW-1:0] pe_sumin;
    logic          busy;
    logic          done;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] m_w [N];

    pe_chain_feeder #(.DATA_W(DW), .SUM_W(SW), .CHAIN_LEN(N), .AW(AW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .start(start), .num_vec(num_vec), .bias(bias),
        .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
        .pe_active(pe_active), .pe_datain(pe_datain), .pe_win(pe_win),
        .pe_wwrite(pe_wwrite), .pe_sumin(pe_sumin), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic wr_weight(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        @(posedge clock); #1;
        cfg_wr_en = 1'b0;
        m_w[a] = d;
    endtask

    // Job schedule: cycle 0 follows the start edge; weights show on cycles 1..N (farthest first);
    // act_ready may rise from cycle N+1; the beat handshaken in cycle c appears in cycle c+1;
    // with L the last-beat cycle (N when num_vec is 0), busy holds through L+N+1 and done is at L+N+2.
    task automatic run_job(input logic [CW-1:0] nv, input logic [SW-1:0] b, input int mode,
                           input bit poke, input bit wr_with_start);
        logic [DW-1:0] snap [N];
        logic [DW-1:0] d, prev_d, new_w3;
        logic [DW-1:0] e_win, e_din;
        logic [SW-1:0] e_sum;
        bit v, exp_ready, hs, prev_hs, finished, e_ww, e_busy, e_done;
        int beats, last_c;
        for (int i = 0; i < N; i++) snap[i] = m_w[i];
        new_w3 = ~m_w[3];
        start = 1'b1; num_vec = nv; bias = b;
        if (wr_with_start) begin
            cfg_wr_en = 1'b1; cfg_wr_addr = 2'd3; cfg_wr_data = new_w3;
        end
        @(posedge clock); #1;
        start = 1'b0; cfg_wr_en = 1'b0;
        if (wr_with_start) m_w[3] = new_w3;
        beats = 0; last_c = (nv == 0) ? N : -1;
        prev_hs = 1'b0; prev_d = '0; finished = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            exp_ready = (c >= N + 1) && (beats < int'(nv));
            case (mode)
                0:       v = 1'b1;
                1:       v = ((c - N - 1) % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = (mode == 2) ? 8'($urandom) : 8'(2 * (beats + 1));
            act_valid = v; act_data = d;
            if (poke && c == N + 2) begin
                start = 1'b1; num_vec = 16'd7;
                cfg_wr_en = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_data = 8'hFF;
            end
            @(negedge clock);
            e_ww   = (c >= 1) && (c <= N);
            e_win  = e_ww ? snap[N - c] : 8'h00;
            e_din  = prev_hs ? prev_d : 8'h00;
            e_sum  = prev_hs ? b : 16'h0000;
            e_busy = (last_c < 0) || (c <= last_c + N + 1);
            e_done = (last_c >= 0) && (c == last_c + N + 2);
            n_vec += 8;
            if (act_ready !== exp_ready) begin
                n_err++; $display("FAIL act_ready c=%0d got=%0b exp=%0b", c, act_ready, exp_ready);
            end
            if (pe_wwrite !== e_ww) begin
                n_err++; $display("FAIL pe_wwrite c=%0d got=%0b exp=%0b", c, pe_wwrite, e_ww);
            end
            if (pe_win !== e_win) begin
                n_err++; $display("FAIL pe_win c=%0d got=%h exp=%h", c, pe_win, e_win);
            end
            if (pe_active !== prev_hs) begin
                n_err++; $display("FAIL pe_active c=%0d got=%0b exp=%0b", c, pe_active, prev_hs);
            end
            if (pe_datain !== e_din) begin
                n_err++; $display("FAIL pe_datain c=%0d got=%h exp=%h", c, pe_datain, e_din);
            end
            if (pe_sumin !== e_sum) begin
                n_err++; $display("FAIL pe_sumin c=%0d got=%h exp=%h", c, pe_sumin, e_sum);
            end
            if (busy !== e_busy) begin
                n_err++; $display("FAIL busy c=%0d got=%0b exp=%0b", c, busy, e_busy);
            end
            if (done !== e_done) begin
                n_err++; $display("FAIL done c=%0d got=%0b exp=%0b", c, done, e_done);
            end
            if (e_done) finished = 1'b1;
            hs = v && exp_ready;
            if (hs) begin
                beats++;
                if (beats == int'(nv)) last_c = c;
            end
            prev_hs = hs; prev_d = d;
            @(posedge clock); #1;
            start = 1'b0; cfg_wr_en = 1'b0; act_valid = 1'b0; act_data = '0;
        end
        n_vec++;
        if (!finished) begin
            n_err++; $display("FAIL job_timeout nv=%0d got=no_done exp=done", nv);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) m_w[i] = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_vec++;
            if ({act_ready, pe_active, pe_datain, pe_win, pe_wwrite, pe_sumin, busy, done} !== '0) begin
                n_err++;
                $display("FAIL reset_idle c=%0d got=%b/%b/%h/%h/%b/%h/%b/%b exp=all0", c, act_ready,
                         pe_active, pe_datain, pe_win, pe_wwrite, pe_sumin, busy, done);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        wr_weight(2'd0, 8'h04); wr_weight(2'd1, 8'h08);
        wr_weight(2'd2, 8'h0C); wr_weight(2'd3, 8'h10);
        run_job(16'd3, 16'h0010, 0, 1'b0, 1'b0);
    endtask

    task automatic test_bubbles();
        run_job(16'd3, 16'h0010, 1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_len();
        run_job(16'd0, 16'h1234, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_while_busy();
        run_job(16'd3, 16'h0042, 0, 1'b1, 1'b0);
        run_job(16'd2, 16'h0043, 0, 1'b0, 1'b0);
    endtask

    task automatic test_write_with_start();
        run_job(16'd2, 16'h0077, 0, 1'b0, 1'b1);
        run_job(16'd1, 16'h0078, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < N; i++) wr_weight(AW'(i), 8'($urandom));
            run_job(16'($urandom_range(1, 7)), 16'($urandom), 2, 1'b0, 1'b0);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < N; i++) wr_weight(AW'(i), 8'($urandom_range(1, 255)));
        start = 1'b1; num_vec = 16'd3; bias = 16'h0055; act_valid = 1'b1; act_data = 8'h09;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (N + 2) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({act_ready, pe_active, pe_datain, pe_win, pe_wwrite, pe_sumin, busy, done} !== '0) begin
            n_err++;
            $display("FAIL abort_immediate got=%b/%b/%h/%h/%b/%h/%b/%b exp=all0", act_ready,
                     pe_active, pe_datain, pe_win, pe_wwrite, pe_sumin, busy, done);
        end
        @(posedge clock); #1;
        reset = 1'b0; act_valid = 1'b0;
        for (int i = 0; i < N; i++) m_w[i] = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL abort_no_done c=%0d got=%b%b exp=00", c, done, busy);
            end
        end
        @(posedge clock); #1;
        run_job(16'd2, 16'h0101, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        start = 1'b0; num_vec = '0; bias = '0; act_valid = 1'b0; act_data = '0;
        test_reset();
        test_basic();
        test_bubbles();
        test_zero_len();
        test_ignore_while_busy();
        test_write_with_start();
        test_random();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_chain_feeder.md
Name: pe_chain_feeder

Overview:
Transmit-side sequencer that drives the input interface of a linear chain of PEs: `wwrite`/`win` to shift weights in, `active`/`datain`/`sumin` to stream activations. It holds a small weight buffer written by the host. On `start` it shifts all weights into the chain, then forwards a counted activation stream from an upstream valid/ready source. Finally it drains the chain and pulses `done`. It sits between the activation buffer/controller and PE0 of each systolic column.

Parameters:
- DATA_W, 8, width of weights and activations (matches PE `datain`/`win`).
- SUM_W, 16, width of partial-sum input (matches PE `sumin`).
- CHAIN_LEN, 4, number of PEs in the chain = number of weights shifted per job.
- AW, 2, weight buffer address width; must equal clog2(CHAIN_LEN).
- CNT_W, 16, width of the activation count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_wr_en  in  1  weight buffer write strobe.
- cfg_wr_addr  in  AW  weight buffer index (0 = PE0).
- cfg_wr_data  in  DATA_W  weight value.
- start  in  1  one-cycle job start request.
- num_vec  in  CNT_W  activations to stream; sampled on accepted start.
- bias  in  SUM_W  partial-sum seed; sampled on accepted start.
- act_valid  in  1  upstream activation valid.
- act_data  in  DATA_W  upstream activation.
- act_ready  out  1  feeder accepts activation this cycle.
- pe_active  out  1  to PE `active`.
- pe_datain  out  DATA_W  to PE `datain`.
- pe_win  out  DATA_W  to PE `win`.
- pe_wwrite  out  1  to PE `wwrite`.
- pe_sumin  out  SUM_W  to PE `sumin`.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0; weight buffer cleared to 0; counters 0.
  - Reset mid-job aborts the job; no done pulse is produced.
- Weight buffer writes:
  - Accepted only in IDLE. A write in any other state is ignored and the buffer is unchanged.
  - A write in the same cycle as an accepted start takes effect and is NOT used by that job's LOAD.
- start:
  - Accepted only in IDLE. Ignored while busy (no queueing).
  - Acceptance latches num_vec and bias, and sets busy=1 on the next edge.
- State machine and transitions:
  - IDLE: outputs idle (pe_* = 0, act_ready=0). Accepted start -> LOAD.
  - LOAD: CHAIN_LEN cycles.
    - Cycle k drives pe_wwrite=1 and pe_win=weight[CHAIN_LEN-1-k], so the farthest PE's weight goes first and PE0 ends holding weight[0].
    - pe_active=0 throughout.
    - After the last cycle -> SETTLE.
  - SETTLE: 1 cycle with pe_wwrite=0, pe_win=0.
    - If latched num_vec==0 -> DRAIN, else -> STREAM.
  - STREAM: act_ready=1.
    - On each handshake (act_valid & act_ready), the next edge gives pe_active=1, pe_datain=act_data, pe_sumin=bias.
    - No handshake gives pe_active=0 and pe_datain=0 on the next edge (bubble).
    - The accepted count increments per handshake.
    - When count == num_vec after an increment, act_ready drops combinationally in the same cycle the last beat is registered; no extra beat is ever accepted. -> DRAIN.
  - DRAIN: CHAIN_LEN cycles with pe_active=0, pe_datain=0, pe_sumin=0, flushing the chain. -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 on the next edge. -> IDLE.
- Output timing and widths:
  - All pe_* outputs, busy and done are registered; 1-cycle latency from the deciding state/handshake.
  - act_ready is combinational: (state==STREAM) && (count < num_vec).
  - The count register is CNT_W bits and never wraps: the maximum num_vec = 2^CNT_W-1 terminates exactly.
- Job length: total busy cycles = CHAIN_LEN + 1 + (STREAM cycles) + CHAIN_LEN + 1.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, act_ready=0, busy=0.
- Write weights 0x04,0x08,0x0C,0x10 to addr 0..3; start with num_vec=3, bias=0x0010; act_valid held 1 with act_data 0x02,0x04,0x06 -> pe_win sequence 0x10,0x0C,0x08,0x04 with pe_wwrite=1 for 4 cycles; then 1 SETTLE cycle; then pe_active=1 for 3 cycles with pe_datain 0x02,0x04,0x06 and pe_sumin=0x0010; then 4 drain cycles; one done pulse.
- Same job, act_valid toggling 1,0,1,0,1 -> pe_active follows the handshakes with bubbles (pe_active=0, pe_datain=0 on bubbles); exactly 3 beats forwarded; act_ready=0 after the 3rd beat even though act_valid=1.
- num_vec=0 -> LOAD, SETTLE, DRAIN only; act_ready never 1; done after 2*CHAIN_LEN+2 busy cycles.
- start pulsed and cfg_wr_en to addr 0 during STREAM -> ignored; the next job shifts the original weights.
- Assert reset in the 2nd STREAM cycle -> outputs 0 immediately, no done pulse; a new start afterwards runs with a cleared (all-zero) weight buffer.
